// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage. Each load/store is latched when
// seen in IDLE, completes after LATENCY busy cycles, and is reported by a
// one-cycle done pulse (with misaligned when addr[1:0] != 0).
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        read_data_q, read_data_d;
  logic               done_q, done_d;
  logic               misaligned_q, misaligned_d;

  // Latched copy of the request; only meaningful while an access is in flight.
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         lo_q, lo_d;
  logic [31:0]        wdata_q, wdata_d;

  // Access performed at the coming edge (live inputs when LATENCY==1).
  logic               acc_en;
  logic               acc_wr;
  logic [IDX_W-1:0]   acc_idx;
  logic [1:0]         acc_lo;
  logic [31:0]        acc_wdata;
  logic               mem_we;
  logic               req;

  logic [31:0]        mem [DEPTH_WORDS];

  // Upper address bits alias onto the array and are deliberately dropped.
  logic               addr_hi_unused;
  assign addr_hi_unused = ^addr[31:IDX_W+2];

  assign req        = mem_read | mem_write;
  assign busy       = ~rst & (((state_q == S_IDLE) & req) | (state_q == S_WAIT));
  assign read_data  = read_data_q;
  assign done       = done_q;
  assign misaligned = misaligned_q;

  // Next-state, request latching and access selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    lo_d      = lo_q;
    wdata_d   = wdata_q;
    acc_en    = 1'b0;
    acc_wr    = wr_q;
    acc_idx   = idx_q;
    acc_lo    = lo_q;
    acc_wdata = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          // A simultaneous read+write is treated as a store.
          wr_d    = mem_write;
          idx_d   = addr[2 +: IDX_W];
          lo_d    = addr[1:0];
          wdata_d = write_data;
          if (LATENCY == 1) begin
            acc_en    = 1'b1;
            acc_wr    = mem_write;
            acc_idx   = addr[2 +: IDX_W];
            acc_lo    = addr[1:0];
            acc_wdata = write_data;
            state_d   = S_DONE;
          end else begin
            cnt_d   = CNT_W'(LATENCY - 2);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          acc_en  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // The same instruction is still in MEM here, so requests are ignored.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Load result, completion pulses and array write enable.
  always_comb begin
    read_data_d  = read_data_q;
    if (acc_en && !acc_wr) begin
      read_data_d = (acc_lo != 2'b00) ? 32'h0 : mem[acc_idx];
    end
    done_d       = (state_d == S_DONE);
    misaligned_d = acc_en & (acc_lo != 2'b00);
    mem_we       = ~rst & acc_en & acc_wr & (acc_lo == 2'b00);
  end

  // Control state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      read_data_q  <= 32'h0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      read_data_q  <= read_data_d;
      done_q       <= done_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Request copy; no reset needed since it is only used after being loaded.
  always_ff @(posedge clk) begin
    wr_q    <= wr_d;
    idx_q   <= idx_d;
    lo_q    <= lo_d;
    wdata_q <= wdata_d;
  end

  // Storage array; never cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a scoreboard of expected
// completions and a small reference model of the word array.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        busy;
  logic        done;
  logic        misaligned;

  typedef struct packed {
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [1024];
  logic [31:0] model_rd;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH_WORDS(1024),
    .LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .write_data(write_data),
    .read_data (read_data),
    .busy      (busy),
    .done      (done),
    .misaligned(misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one access from an IDLE cycle and follow it through to the cycle after done.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd);
    exp_t       e;
    int         cyc;
    int         bcnt;
    logic [9:0] i;
    i     = a[11:2];
    e.mis = (a[1:0] != 2'b00);
    if (wr) begin
      if (!e.mis) model_mem[i] = wd;
      e.rd = model_rd;
    end else begin
      e.rd     = e.mis ? 32'h0 : model_mem[i];
      model_rd = e.rd;
    end
    sb.push_back(e);
    mem_read   = rd;
    mem_write  = wr;
    addr       = a;
    write_data = wd;
    #1;
    chk({tag, " busy_at_req"}, 32'(busy), 32'd1);
    cyc  = 0;
    bcnt = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, " done_latency"}, 32'(cyc), 32'(LAT));
    chk({tag, " busy_cycles"}, 32'(bcnt), 32'(LAT));
    chk({tag, " busy_in_done"}, 32'(busy), 32'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " read_data"}, read_data, e.rd);
      chk({tag, " misaligned"}, 32'(misaligned), 32'(e.mis));
    end else begin
      chk({tag, " scoreboard_underflow"}, 32'd1, 32'd0);
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " done_pulse_end"}, 32'(done), 32'd0);
    chk({tag, " mis_pulse_end"}, 32'(misaligned), 32'd0);
  endtask

  initial begin
    rst        = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr       = 32'h0;
    write_data = 32'h0;
    model_rd   = 32'h0;

    // Power-on reset
    #2 rst = 1'b1;
    #1;
    chk("reset read_data", read_data, 32'h0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset misaligned", 32'(misaligned), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Store then load, and a back-to-back pair
    access("t2 store", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    access("t2 load",  1'b1, 1'b0, 32'h10, 32'h0);
    access("t3 store", 1'b0, 1'b1, 32'h20, 32'h12345678);
    access("t3 load",  1'b1, 1'b0, 32'h20, 32'h0);

    // Misaligned accesses
    access("t4 mis store", 1'b0, 1'b1, 32'h13, 32'hFFFFFFFF);
    access("t4 load",      1'b1, 1'b0, 32'h10, 32'h0);
    access("t4 mis load",  1'b1, 1'b0, 32'h11, 32'h0);

    // Asynchronous reset while done is high
    mem_read = 1'b1;
    addr     = 32'h20;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("t1 done before rst", 32'(done), 32'd1);
    chk("t1 data before rst", read_data, 32'h12345678);
    #2 rst = 1'b1;
    #1;
    chk("t1 rst read_data", read_data, 32'h0);
    chk("t1 rst done", 32'(done), 32'd0);
    chk("t1 rst busy", 32'(busy), 32'd0);
    mem_read = 1'b0;
    model_rd = 32'h0;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset during WAIT of a store aborts it
    access("t5 prestore", 1'b0, 1'b1, 32'h40, 32'h11112222);
    mem_write  = 1'b1;
    addr       = 32'h40;
    write_data = 32'hAAAA5555;
    @(posedge clk);
    #1;
    chk("t5 busy in wait", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5 busy under rst", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("t5 busy under rst edge", 32'(busy), 32'd0);
    chk("t5 done under rst", 32'(done), 32'd0);
    mem_write = 1'b0;
    #2 rst = 1'b0;
    model_rd = 32'h0;
    @(posedge clk);
    #1;
    access("t5 load", 1'b1, 1'b0, 32'h40, 32'h0);

    // Address aliasing and read+write treated as store
    access("t6 alias store", 1'b0, 1'b1, 32'h1000, 32'hCAFEF00D);
    access("t6 alias load",  1'b1, 1'b0, 32'h0, 32'h0);
    access("t6 rw store",    1'b1, 1'b1, 32'h8, 32'h5A5A5A5A);
    access("t6 rw load",     1'b1, 1'b0, 32'h8, 32'h0);

    chk("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
